// File: rtl/nv_nvdla_cvif_write_cq_if.sv
// Handshake bundle between write ingress, the context queue and write egress.
//   slave  : the context queue side (accepts writes, presents five heads)
//   master : the surrounding logic side (issues writes, consumes heads)
// Signals:
//   cq_wr_pvld/prdy/thread_id/pd : single write port, thread_id selects queue 0..4
//   cq_rdN_pvld/prdy/pd          : per-thread head entry, N = 0..4
//   cq_idle                      : all thread queues empty
interface nv_nvdla_cvif_write_cq_if;
  logic       cq_wr_pvld;
  logic       cq_wr_prdy;
  logic [2:0] cq_wr_thread_id;
  logic [2:0] cq_wr_pd;
  logic       cq_rd0_pvld, cq_rd1_pvld, cq_rd2_pvld, cq_rd3_pvld, cq_rd4_pvld;
  logic       cq_rd0_prdy, cq_rd1_prdy, cq_rd2_prdy, cq_rd3_prdy, cq_rd4_prdy;
  logic [2:0] cq_rd0_pd, cq_rd1_pd, cq_rd2_pd, cq_rd3_pd, cq_rd4_pd;
  logic       cq_idle;

  modport slave (
    input  cq_wr_pvld, cq_wr_thread_id, cq_wr_pd,
    input  cq_rd0_prdy, cq_rd1_prdy, cq_rd2_prdy, cq_rd3_prdy, cq_rd4_prdy,
    output cq_wr_prdy,
    output cq_rd0_pvld, cq_rd1_pvld, cq_rd2_pvld, cq_rd3_pvld, cq_rd4_pvld,
    output cq_rd0_pd, cq_rd1_pd, cq_rd2_pd, cq_rd3_pd, cq_rd4_pd,
    output cq_idle
  );

  modport master (
    output cq_wr_pvld, cq_wr_thread_id, cq_wr_pd,
    output cq_rd0_prdy, cq_rd1_prdy, cq_rd2_prdy, cq_rd3_prdy, cq_rd4_prdy,
    input  cq_wr_prdy,
    input  cq_rd0_pvld, cq_rd1_pvld, cq_rd2_pvld, cq_rd3_pvld, cq_rd4_pvld,
    input  cq_rd0_pd, cq_rd1_pd, cq_rd2_pd, cq_rd3_pd, cq_rd4_pd,
    input  cq_idle
  );
endinterface

// File: rtl/nv_nvdla_cvif_write_cq.sv
// Write context queue: five independent per-thread FIFOs of 3-bit context
// entries ({len[1:0], require_ack}). One shared write port selects a thread;
// each thread presents its head entry to write egress with no read latency.
// Ports:
//   nvdla_core_clk : clock, all state updates on rising edge
//   nvdla_core_rst : synchronous active-high reset, clears pointers, counts, storage
//   cq             : slave modport of nv_nvdla_cvif_write_cq_if
// Heads are driven from registered state only, so a pushed entry appears on
// its thread's read port one cycle after the accepting edge.
module nv_nvdla_cvif_write_cq #(
  parameter int DEPTH = 8,
  parameter int NTHR  = 5
) (
  input  logic                          nvdla_core_clk,
  input  logic                          nvdla_core_rst,
  nv_nvdla_cvif_write_cq_if.slave       cq
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0]   ZERO_CNT = {(AW+1){1'b0}};
  localparam logic [AW-1:0] ZERO_PTR = {AW{1'b0}};

  logic [2:0]      storage_r [NTHR][DEPTH];
  logic [AW-1:0]   wr_ptr_r  [NTHR];
  logic [AW-1:0]   rd_ptr_r  [NTHR];
  logic [AW:0]     count_r   [NTHR];

  logic [NTHR-1:0] rd_pvld_s;
  logic [NTHR-1:0] rd_prdy_s;
  logic [NTHR-1:0] push_s;
  logic [NTHR-1:0] pop_s;
  logic [2:0]      rd_pd_s   [NTHR];
  logic            wr_prdy_s;
  logic            idle_s;

  // Gather the per-thread read-ready strobes into a vector.
  always_comb begin
    rd_prdy_s = {cq.cq_rd4_prdy, cq.cq_rd3_prdy, cq.cq_rd2_prdy,
                 cq.cq_rd1_prdy, cq.cq_rd0_prdy};
  end

  // Write ready: legal thread id with space left. A pop in the same cycle
  // does not open a full queue; space shows up on the following cycle.
  always_comb begin
    wr_prdy_s = 1'b0;
    case (cq.cq_wr_thread_id)
      3'd0:    wr_prdy_s = (count_r[0] != FULL_CNT);
      3'd1:    wr_prdy_s = (count_r[1] != FULL_CNT);
      3'd2:    wr_prdy_s = (count_r[2] != FULL_CNT);
      3'd3:    wr_prdy_s = (count_r[3] != FULL_CNT);
      3'd4:    wr_prdy_s = (count_r[4] != FULL_CNT);
      default: wr_prdy_s = 1'b0;
    endcase
  end

  // Per-thread head view, push/pop decode and idle.
  always_comb begin
    idle_s = 1'b1;
    for (int i = 0; i < NTHR; i++) begin
      rd_pvld_s[i] = (count_r[i] != ZERO_CNT);
      rd_pd_s[i]   = storage_r[i][rd_ptr_r[i]];
      pop_s[i]     = rd_pvld_s[i] & rd_prdy_s[i];
      push_s[i]    = cq.cq_wr_pvld & wr_prdy_s & (cq.cq_wr_thread_id == 3'(i));
      if (rd_pvld_s[i]) begin
        idle_s = 1'b0;
      end else begin
        idle_s = idle_s;
      end
    end
  end

  // Queue state: storage, pointers and occupancy per thread.
  always_ff @(posedge nvdla_core_clk) begin
    if (nvdla_core_rst) begin
      for (int i = 0; i < NTHR; i++) begin
        wr_ptr_r[i] <= ZERO_PTR;
        rd_ptr_r[i] <= ZERO_PTR;
        count_r[i]  <= ZERO_CNT;
        for (int j = 0; j < DEPTH; j++) begin
          storage_r[i][j] <= 3'b000;
        end
      end
    end else begin
      for (int i = 0; i < NTHR; i++) begin
        if (push_s[i]) begin
          storage_r[i][wr_ptr_r[i]] <= cq.cq_wr_pd;
          wr_ptr_r[i]               <= wr_ptr_r[i] + AW'(1'b1);
        end
        if (pop_s[i]) begin
          rd_ptr_r[i] <= rd_ptr_r[i] + AW'(1'b1);
        end
        case ({push_s[i], pop_s[i]})
          2'b10:   count_r[i] <= count_r[i] + (AW+1)'(1'b1);
          2'b01:   count_r[i] <= count_r[i] - (AW+1)'(1'b1);
          default: count_r[i] <= count_r[i];
        endcase
      end
    end
  end

  assign cq.cq_wr_prdy  = wr_prdy_s;
  assign cq.cq_rd0_pvld = rd_pvld_s[0];
  assign cq.cq_rd1_pvld = rd_pvld_s[1];
  assign cq.cq_rd2_pvld = rd_pvld_s[2];
  assign cq.cq_rd3_pvld = rd_pvld_s[3];
  assign cq.cq_rd4_pvld = rd_pvld_s[4];
  assign cq.cq_rd0_pd   = rd_pd_s[0];
  assign cq.cq_rd1_pd   = rd_pd_s[1];
  assign cq.cq_rd2_pd   = rd_pd_s[2];
  assign cq.cq_rd3_pd   = rd_pd_s[3];
  assign cq.cq_rd4_pd   = rd_pd_s[4];
  assign cq.cq_idle     = idle_s;

endmodule

// File: tb/tb_nv_nvdla_cvif_write_cq.sv
// Bench for the write context queue: directed scenarios followed by random
// traffic, every cycle compared against a queue-based model of the five FIFOs.
module tb_nv_nvdla_cvif_write_cq;
  localparam int DEPTH = 8;

  logic nvdla_core_clk = 1'b0;
  logic nvdla_core_rst = 1'b1;

  nv_nvdla_cvif_write_cq_if cq_if ();

  nv_nvdla_cvif_write_cq #(.DEPTH(DEPTH), .NTHR(5)) u_dut (
    .nvdla_core_clk (nvdla_core_clk),
    .nvdla_core_rst (nvdla_core_rst),
    .cq             (cq_if.slave)
  );

  always #5 nvdla_core_clk = ~nvdla_core_clk;

  logic [4:0] rd_pvld_s;
  logic [2:0] rd_pd_s [5];
  assign rd_pvld_s  = {cq_if.cq_rd4_pvld, cq_if.cq_rd3_pvld, cq_if.cq_rd2_pvld,
                       cq_if.cq_rd1_pvld, cq_if.cq_rd0_pvld};
  assign rd_pd_s[0] = cq_if.cq_rd0_pd;
  assign rd_pd_s[1] = cq_if.cq_rd1_pd;
  assign rd_pd_s[2] = cq_if.cq_rd2_pd;
  assign rd_pd_s[3] = cq_if.cq_rd3_pd;
  assign rd_pd_s[4] = cq_if.cq_rd4_pd;

  typedef logic [2:0] entry_q_t [$];
  entry_q_t mq [5];

  int  checks = 0;
  int  errors = 0;
  bit  check_en = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  // One cycle: drive inputs, compare outputs against the model before the
  // edge, then advance the model with what the edge commits.
  task automatic step(input logic rst, input logic pvld, input logic [2:0] id,
                      input logic [2:0] pd, input logic [4:0] prdy);
    bit exp_wr_prdy;
    bit all_empty;
    nvdla_core_rst        = rst;
    cq_if.cq_wr_pvld      = pvld;
    cq_if.cq_wr_thread_id = id;
    cq_if.cq_wr_pd        = pd;
    {cq_if.cq_rd4_prdy, cq_if.cq_rd3_prdy, cq_if.cq_rd2_prdy,
     cq_if.cq_rd1_prdy, cq_if.cq_rd0_prdy} = prdy;
    #1;
    exp_wr_prdy = (id <= 3'd4) ? (mq[id].size() < DEPTH) : 1'b0;
    all_empty   = 1'b1;
    for (int t = 0; t < 5; t++) if (mq[t].size() != 0) all_empty = 1'b0;
    if (check_en) begin
      chk("wr_prdy", {31'd0, cq_if.cq_wr_prdy}, {31'd0, exp_wr_prdy});
      chk("idle", {31'd0, cq_if.cq_idle}, {31'd0, all_empty});
      for (int t = 0; t < 5; t++) begin
        chk($sformatf("rd%0d_pvld", t), {31'd0, rd_pvld_s[t]}, {31'd0, mq[t].size() != 0});
        if (mq[t].size() != 0)
          chk($sformatf("rd%0d_pd", t), {29'd0, rd_pd_s[t]}, {29'd0, mq[t][0]});
      end
    end
    @(posedge nvdla_core_clk);
    if (rst) begin
      for (int t = 0; t < 5; t++) mq[t].delete();
    end else begin
      for (int t = 0; t < 5; t++)
        if (prdy[t] && mq[t].size() != 0) void'(mq[t].pop_front());
      if (pvld && exp_wr_prdy) mq[id].push_back(pd);
    end
    @(negedge nvdla_core_clk);
  endtask

  task automatic chk_all_pd_zero(input string tag);
    for (int t = 0; t < 5; t++)
      chk($sformatf("%s_pd%0d", tag, t), {29'd0, rd_pd_s[t]}, 32'd0);
  endtask

  initial begin
    cq_if.cq_wr_pvld = 1'b0;
    cq_if.cq_wr_thread_id = 3'd0;
    cq_if.cq_wr_pd = 3'd0;
    {cq_if.cq_rd4_prdy, cq_if.cq_rd3_prdy, cq_if.cq_rd2_prdy,
     cq_if.cq_rd1_prdy, cq_if.cq_rd0_prdy} = 5'd0;
    @(negedge nvdla_core_clk);
    step(1'b1, 1'b0, 3'd0, 3'd0, 5'd0);
    step(1'b1, 1'b1, 3'd1, 3'd5, 5'h1f);
    check_en = 1'b1;
    #1;
    chk_all_pd_zero("reset");
    for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 3'(i), 3'd0, 5'd0);

    // single push to thread 2, visible next cycle, then popped
    step(1'b0, 1'b1, 3'd2, 3'b101, 5'd0);
    step(1'b0, 1'b0, 3'd2, 3'd0, 5'd0);
    step(1'b0, 1'b0, 3'd2, 3'd0, 5'b00100);

    // fill thread 0; 9th push refused, other thread still ready
    for (int i = 0; i < 9; i++) step(1'b0, 1'b1, 3'd0, 3'(i), 5'd0);
    step(1'b0, 1'b0, 3'd1, 3'd0, 5'd0);
    step(1'b0, 1'b1, 3'd0, 3'd7, 5'd0);

    // full with same-cycle pop: no push, ready returns next cycle
    step(1'b0, 1'b1, 3'd0, 3'd7, 5'b00001);
    step(1'b0, 1'b1, 3'd0, 3'd3, 5'd0);
    for (int i = 0; i < 9; i++) step(1'b0, 1'b0, 3'd0, 3'd0, 5'b00001);

    // wrap-around on thread 4 with interleaved push/pop
    for (int i = 0; i < 20; i++) step(1'b0, 1'b1, 3'd4, 3'(i % 8), {i[0], 4'b0000});
    for (int i = 0; i < 12; i++) step(1'b0, 1'b0, 3'd4, 3'd0, 5'b10000);

    // illegal ids
    for (int i = 5; i < 8; i++) step(1'b0, 1'b1, 3'(i), 3'd6, 5'd0);

    // reset mid-run with threads 1 and 3 holding three entries, plus a
    // push and pops presented during the reset cycle
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b1, 3'd1, 3'(i + 1), 5'd0);
      step(1'b0, 1'b1, 3'd3, 3'(i + 4), 5'd0);
    end
    step(1'b1, 1'b1, 3'd2, 3'd7, 5'b01010);
    #1;
    chk_all_pd_zero("midrst");
    step(1'b0, 1'b0, 3'd0, 3'd0, 5'd0);

    // random traffic, with phases of sparse and dense draining
    for (int i = 0; i < 3000; i++) begin
      logic [4:0] prdy;
      int dense;
      dense = ((i / 200) % 2 == 0) ? 4 : 1;
      for (int t = 0; t < 5; t++) prdy[t] = ($urandom_range(0, 4) < dense);
      step(($urandom_range(0, 299) == 0), 1'($urandom_range(0, 1)),
           3'($urandom_range(0, 7)), 3'($urandom), prdy);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/nv_nvdla_cvif_write_cq.md
NV_NVDLA_CVIF_WRITE_CQ -- requirements
Module: NV_NVDLA_CVIF_WRITE_cq

Interface
REQ-001 SHALL have parameter DEPTH, default 8: entries per thread queue; power of two, 2..16.
REQ-002 SHALL have parameter NTHR, default 5: number of thread queues, fixed at 5 in this release.
REQ-003 nvdla_core_clk  in  1  sole clock; all state updates on its rising edge.
REQ-004 nvdla_core_rst  in  1  reset, synchronous and active-high.
REQ-005 cq_wr_pvld  in  1  write request valid, from write ingress.
REQ-006 cq_wr_prdy  out  1  write request accepted.
REQ-007 cq_wr_thread_id  in  3  target thread queue, 0..4.
REQ-008 cq_wr_pd  in  3  context entry: [2:1]=len (beats-1), [0]=require_ack.
REQ-009 cq_rdN_pvld  out  1  (N=0..4) thread N head entry valid, to write egress.
REQ-010 cq_rdN_prdy  in  1  (N=0..4) thread N head entry consumed.
REQ-011 cq_rdN_pd  out  3  (N=0..4) thread N head entry, same format as cq_wr_pd.
REQ-012 cq_idle  out  1  all five queues empty.

Function
REQ-013 SHALL implement five independent FIFOs, each DEPTH entries of 3 bits, with a write pointer, a read pointer (log2(DEPTH) bits, wrapping modulo DEPTH) and an occupancy count (log2(DEPTH)+1 bits, range 0..DEPTH).
REQ-014 cq_wr_prdy SHALL be combinational: 1 iff cq_wr_thread_id <= 4 and count[cq_wr_thread_id] < DEPTH; independent of cq_wr_pvld.
REQ-015 cq_wr_thread_id 5..7 SHALL give cq_wr_prdy=0; nothing is written, and state is unchanged.
REQ-016 Push occurs iff cq_wr_pvld & cq_wr_prdy: cq_wr_pd is stored at wr_ptr[id], wr_ptr[id]+1, and count[id]+1 (unless a same-thread pop occurs).
REQ-017 cq_rdN_pvld SHALL equal (count[N] != 0), taken from registered state only; there SHALL be no same-cycle bypass from write to read.
REQ-018 Write-to-read latency SHALL be 1 cycle: an entry pushed at edge T is visible on cq_rdN_pvld/pd in the cycle after T.
REQ-019 cq_rdN_pd SHALL equal storage[N][rd_ptr[N]] combinationally, with no read latency.
REQ-020 Pop occurs iff cq_rdN_pvld & cq_rdN_prdy: rd_ptr[N]+1 and count[N]-1; a prdy with pvld=0 SHALL have no effect.
REQ-021 Push and pop on the same thread in one cycle SHALL leave count unchanged and move both pointers.
REQ-022 A full queue SHALL keep cq_wr_prdy=0 for that thread even when a same-cycle pop occurs (no full-bypass); prdy rises the cycle after the pop.
REQ-023 Pops on multiple threads in one cycle SHALL all be honoured.
REQ-024 Entries SHALL leave each thread in push order; there is no ordering across threads.
REQ-025 cq_idle SHALL be registered-state-based: 1 iff all five counts are 0.
REQ-026 Overflow and underflow SHALL be impossible by construction; count never exceeds DEPTH and never goes below 0.

Reset
REQ-027 While nvdla_core_rst=1 at an edge: all pointers and counts SHALL be 0, and all storage SHALL be 0.
REQ-028 From the cycle after reset: cq_rdN_pvld=0, cq_rdN_pd=0, cq_idle=1, and cq_wr_prdy=1 for thread id 0..4.
REQ-029 Reset asserted mid-operation SHALL discard all queued entries at that edge; any push or pop presented in the same cycle SHALL be ignored.

Verification
REQ-030 Single push: id=2, pd=3'b101 at cycle 0 -> cycle 1: cq_rd2_pvld=1, cq_rd2_pd=3'b101, cq_idle=0; other pvld remain 0.
REQ-031 Fill: 8 pushes to thread 0 with no pops -> after the 8th, cq_wr_prdy=0 for id 0 and 1 for id 1; a 9th push is not accepted, and the queue holds the first 8 in order.
REQ-032 Full plus same-cycle pop: thread 0 full, cq_rd0_prdy=1 with cq_wr_pvld=1 id=0 -> no push that cycle, count=7; the next cycle cq_wr_prdy=1.
REQ-033 Wrap-around: 20 interleaved pushes and pops on thread 4 with pd=i mod 8 -> output sequence matches exactly; count returns to 0 and cq_idle=1.
REQ-034 Illegal id: cq_wr_pvld=1, id=6 -> cq_wr_prdy=0 and all counts are unchanged.
REQ-035 Reset mid-run: threads 1 and 3 hold 3 entries each, then nvdla_core_rst=1 for 1 cycle -> the next cycle shows all pvld=0, pd=0, and cq_idle=1.
